// File: rtl/regfile_2r1w_sb_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_2r1w_sb_if
// Brief  : Operand-fetch / writeback / scoreboard bundle for regfile_2r1w_sb.
// Rev    : 1.0 - initial release
// ============================================================================
interface regfile_2r1w_sb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] writenum;
    logic                  write;
    logic [ADDR_WIDTH-1:0] readnum_a;
    logic [ADDR_WIDTH-1:0] readnum_b;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic [DATA_WIDTH-1:0] data_out_b;
    logic                  reserve;
    logic [ADDR_WIDTH-1:0] reservenum;
    logic                  busy_a;
    logic                  busy_b;
    logic [NUM_REGS-1:0]   busy_vec;

    modport master (
        output data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
        input  data_out_a, data_out_b, busy_a, busy_b, busy_vec
    );

    modport slave (
        input  data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
        output data_out_a, data_out_b, busy_a, busy_b, busy_vec
    );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
// Module : regfile_2r1w_sb
// Brief  : Parametrised 2-read/1-write register file with busy scoreboard.
//          Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_2r1w_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    regfile_2r1w_sb_if.slave   bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic [DATA_WIDTH-1:0] w_rd_data_a;
    logic [DATA_WIDTH-1:0] w_rd_data_b;
    logic                  w_rd_busy_a;
    logic                  w_rd_busy_b;

    // Out-of-range register numbers never match any loop index, so they are
    // dropped for write/reserve and read back as zero.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.write && (bus.writenum == ADDR_WIDTH'(i))) begin
                mem_d[i]  = bus.data_in;
                busy_d[i] = 1'b0;
            end
            // A same-cycle reservation means a newer producer is in flight.
            if (bus.reserve && (bus.reservenum == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        w_rd_data_a = '0;
        w_rd_busy_a = 1'b0;
        w_rd_data_b = '0;
        w_rd_busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.readnum_a == ADDR_WIDTH'(i)) begin
                w_rd_data_a = mem_q[i];
                w_rd_busy_a = busy_q[i];
            end
            if (bus.readnum_b == ADDR_WIDTH'(i)) begin
                w_rd_data_b = mem_q[i];
                w_rd_busy_b = busy_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_WIDTH:0] C_NUM_REGS = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic w_wr_valid;
    logic w_byp_busy;
    logic w_byp_a;
    logic w_byp_b;

    // Forwarded busy reflects the post-edge scoreboard of the written register.
    assign w_wr_valid = bus.write && !reset && ({1'b0, bus.writenum} < C_NUM_REGS);
    assign w_byp_busy = bus.reserve && (bus.reservenum == bus.writenum);
    assign w_byp_a    = w_wr_valid && (bus.readnum_a == bus.writenum);
    assign w_byp_b    = w_wr_valid && (bus.readnum_b == bus.writenum);

    assign bus.data_out_a = w_byp_a ? bus.data_in : w_rd_data_a;
    assign bus.data_out_b = w_byp_b ? bus.data_in : w_rd_data_b;
    assign bus.busy_a     = w_byp_a ? w_byp_busy  : w_rd_busy_a;
    assign bus.busy_b     = w_byp_b ? w_byp_busy  : w_rd_busy_b;
`else
    assign bus.data_out_a = w_rd_data_a;
    assign bus.data_out_b = w_rd_data_b;
    assign bus.busy_a     = w_rd_busy_a;
    assign bus.busy_b     = w_rd_busy_b;
`endif

    assign bus.busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_2r1w_sb
// Brief  : Self-checking bench for regfile_2r1w_sb (8- and 6-entry instances).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_2r1w_sb_if #(.DATA_WIDTH(16), .NUM_REGS(8)) bus8 ();
    regfile_2r1w_sb_if #(.DATA_WIDTH(16), .NUM_REGS(6)) bus6 ();

    regfile_2r1w_sb #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    regfile_2r1w_sb #(.DATA_WIDTH(16), .NUM_REGS(6)) dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6.slave)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic [2:0]  wnum;
        logic [15:0] din;
        logic        rsv;
        logic [2:0]  rnum;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eba;
        logic        ebb;
        logic [7:0]  evec;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic rst, logic wr, logic [2:0] wnum, logic [15:0] din,
                                logic rsv, logic [2:0] rnum, logic [2:0] ra, logic [2:0] rb,
                                logic [15:0] ea, logic [15:0] eb, logic eba, logic ebb,
                                logic [7:0] evec);
        vec_t v;
        v.rst = rst; v.wr = wr; v.wnum = wnum; v.din = din; v.rsv = rsv; v.rnum = rnum;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.evec = evec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        bus8.write = 1'b0; bus8.reserve = 1'b0; bus8.writenum = '0; bus8.reservenum = '0;
        bus8.data_in = '0;
        bus6.write = 1'b0; bus6.reserve = 1'b0; bus6.writenum = '0; bus6.reservenum = '0;
        bus6.data_in = '0; bus6.readnum_a = '0; bus6.readnum_b = '0;
    endtask

    initial begin
        vec_t e;
        //            rst wr wnum din       rsv rnum ra rb  ea        eb        ba bb vec
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00);
        vecs[1]  = mk(1, 1, 3, 16'hBEEF, 0, 0, 3, 3, 16'h0000, 16'h0000, 0, 0, 8'h00);
        vecs[2]  = mk(0, 1, 2, 16'h1234, 0, 0, 2, 3, 16'h1234, 16'h0000, 0, 0, 8'h00);
        vecs[3]  = mk(0, 1, 7, 16'hABCD, 0, 0, 2, 7, 16'h1234, 16'hABCD, 0, 0, 8'h00);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 7, 7, 16'hABCD, 16'hABCD, 0, 0, 8'h00);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 1, 5, 5, 2, 16'h0000, 16'h1234, 1, 0, 8'h20);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 1, 5, 5, 5, 16'h0000, 16'h0000, 1, 1, 8'h20);
        vecs[7]  = mk(0, 1, 5, 16'h0042, 0, 0, 5, 7, 16'h0042, 16'hABCD, 0, 0, 8'h00);
        vecs[8]  = mk(0, 1, 4, 16'h5555, 1, 4, 4, 5, 16'h5555, 16'h0042, 1, 0, 8'h10);
        vecs[9]  = mk(0, 1, 6, 16'h6666, 1, 1, 1, 6, 16'h0000, 16'h6666, 1, 0, 8'h12);
        vecs[10] = mk(0, 1, 1, 16'h1111, 0, 0, 1, 4, 16'h1111, 16'h5555, 0, 1, 8'h10);
        vecs[11] = mk(0, 1, 0, 16'hFFFF, 0, 0, 0, 2, 16'hFFFF, 16'h1234, 0, 0, 8'h10);
        vecs[12] = mk(1, 1, 2, 16'h9999, 1, 3, 2, 4, 16'h0000, 16'h0000, 0, 0, 8'h00);

        idle_all();
        bus8.readnum_a = '0; bus8.readnum_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Post-reset sweep of every register on both ports of both instances.
        for (int r = 0; r < 8; r++) begin
            bus8.readnum_a = 3'(r);
            bus8.readnum_b = 3'(7 - r);
            bus6.readnum_a = 3'(r);
            #1;
            chk($sformatf("rst data_a r%0d", r), 32'(bus8.data_out_a), 32'h0);
            chk($sformatf("rst data_b r%0d", 7 - r), 32'(bus8.data_out_b), 32'h0);
            chk($sformatf("rst busy r%0d", r), 32'({bus8.busy_a, bus8.busy_b}), 32'h0);
            chk($sformatf("rst6 data_a r%0d", r), 32'(bus6.data_out_a), 32'h0);
        end
        chk("rst busy_vec", 32'(bus8.busy_vec), 32'h0);
        chk("rst6 busy_vec", 32'(bus6.busy_vec), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset           = vecs[i].rst;
            bus8.write      = vecs[i].wr;
            bus8.writenum   = vecs[i].wnum;
            bus8.data_in    = vecs[i].din;
            bus8.reserve    = vecs[i].rsv;
            bus8.reservenum = vecs[i].rnum;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            reset = 1'b0;
            bus8.write = 1'b0;
            bus8.reserve = 1'b0;
            bus8.readnum_a = vecs[i].ra;
            bus8.readnum_b = vecs[i].rb;
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d data_a", i), 32'(bus8.data_out_a), 32'(e.ea));
            chk($sformatf("v%0d data_b", i), 32'(bus8.data_out_b), 32'(e.eb));
            chk($sformatf("v%0d busy_a", i), 32'(bus8.busy_a), 32'(e.eba));
            chk($sformatf("v%0d busy_b", i), 32'(bus8.busy_b), 32'(e.ebb));
            chk($sformatf("v%0d busy_vec", i), 32'(bus8.busy_vec), 32'(e.evec));
        end

        // Same-cycle visibility of a write (forwarded only with bypass).
        @(negedge clk);
        bus8.write = 1'b1; bus8.writenum = 3'd0; bus8.data_in = 16'h00AA;
        bus8.readnum_b = 3'd0; bus8.readnum_a = 3'd1;
        #1;
        chk("same-cycle data_b", 32'(bus8.data_out_b), C_BYP ? 32'h00AA : 32'h0);
        chk("same-cycle busy_b", 32'(bus8.busy_b), 32'h0);
        chk("same-cycle data_a other", 32'(bus8.data_out_a), 32'h0);
        @(posedge clk);
        #1 bus8.write = 1'b0;
        #1 chk("next-cycle data_b", 32'(bus8.data_out_b), 32'h00AA);

        @(negedge clk);
        bus8.write = 1'b1; bus8.writenum = 3'd3; bus8.data_in = 16'h3333;
        bus8.reserve = 1'b1; bus8.reservenum = 3'd3; bus8.readnum_a = 3'd3;
        #1;
        chk("same-cycle wr+rsv data_a", 32'(bus8.data_out_a), C_BYP ? 32'h3333 : 32'h0);
        chk("same-cycle wr+rsv busy_a", 32'(bus8.busy_a), C_BYP ? 32'h1 : 32'h0);
        @(posedge clk);
        #1 bus8.write = 1'b0; bus8.reserve = 1'b0;
        #1;
        chk("wr+rsv data_a", 32'(bus8.data_out_a), 32'h3333);
        chk("wr+rsv busy_a", 32'(bus8.busy_a), 32'h1);

        @(negedge clk);
        reset = 1'b1;
        bus8.write = 1'b1; bus8.writenum = 3'd0; bus8.data_in = 16'h7777; bus8.readnum_b = 3'd0;
        #1 chk("reset-suppress data_b", 32'(bus8.data_out_b), 32'h00AA);
        @(posedge clk);
        #1 reset = 1'b0; bus8.write = 1'b0;
        #1;
        chk("reset-during-write data_b", 32'(bus8.data_out_b), 32'h0);
        chk("reset-during-write busy_vec", 32'(bus8.busy_vec), 32'h0);

        // 6-entry instance: out-of-range write/reserve/read.
        @(negedge clk);
        bus6.write = 1'b1; bus6.writenum = 3'd7; bus6.data_in = 16'hFFFF;
        bus6.reserve = 1'b1; bus6.reservenum = 3'd6; bus6.readnum_a = 3'd7;
        #1 chk("n6 oor same-cycle data_a", 32'(bus6.data_out_a), 32'h0);
        @(posedge clk);
        #1 bus6.write = 1'b0; bus6.reserve = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus6.readnum_a = 3'(r);
            #1;
            chk($sformatf("n6 data_a r%0d", r), 32'(bus6.data_out_a), 32'h0);
            chk($sformatf("n6 busy_a r%0d", r), 32'(bus6.busy_a), 32'h0);
        end
        chk("n6 busy_vec oor", 32'(bus6.busy_vec), 32'h0);

        @(negedge clk);
        bus6.write = 1'b1; bus6.writenum = 3'd5; bus6.data_in = 16'h0505;
        bus6.reserve = 1'b1; bus6.reservenum = 3'd2;
        @(posedge clk);
        #1 bus6.write = 1'b0; bus6.reserve = 1'b0;
        bus6.readnum_a = 3'd5; bus6.readnum_b = 3'd6;
        #1;
        chk("n6 data_a r5", 32'(bus6.data_out_a), 32'h0505);
        chk("n6 data_b r6", 32'(bus6.data_out_b), 32'h0);
        chk("n6 busy_b r6", 32'(bus6.busy_b), 32'h0);
        chk("n6 busy_vec", 32'(bus6.busy_vec), 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
